// File: rtl/mem_port_responder.sv
// Memory-port responder: round-robin arbitration of per-processor block
// read/write requests onto a single memory port, one transaction at a time,
// with a one-cycle per-port acknowledge and a held read-data register.
module mem_port_responder #(
    parameter int NUM_PORTS       = 4,
    parameter int WORD_SIZE       = 32,
    parameter int BLOCK_SIZE      = 3,
    parameter int MEMORY_SIZE     = 1024,
    parameter int LOG_MEMORY_SIZE = $clog2(MEMORY_SIZE),
    parameter int READ_LATENCY    = 1
) (
    input  logic                                       in_clk,
    input  logic                                       in_reset,
    input  logic [NUM_PORTS-1:0]                       in_req,
    input  logic [NUM_PORTS-1:0]                       in_we,
    input  logic [NUM_PORTS*LOG_MEMORY_SIZE-1:0]       in_addr,
    input  logic [NUM_PORTS*BLOCK_SIZE*WORD_SIZE-1:0]  in_wdata,
    output logic [NUM_PORTS-1:0]                       out_ack,
    output logic [NUM_PORTS-1:0]                       out_rvalid,
    output logic [BLOCK_SIZE*WORD_SIZE-1:0]            out_rdata,
    output logic [LOG_MEMORY_SIZE-1:0]                 out_mem_address,
    output logic [BLOCK_SIZE*WORD_SIZE-1:0]            out_mem_data,
    output logic                                       out_mem_read_en,
    output logic                                       out_mem_write_en,
    input  logic [BLOCK_SIZE*WORD_SIZE-1:0]            in_mem_data
);

    localparam int BLOCK_W = BLOCK_SIZE * WORD_SIZE;
    localparam int PTR_W   = $clog2(NUM_PORTS);
    localparam int CNT_W   = $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     sel_q, sel_d;
    logic                 we_q, we_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [LOG_MEMORY_SIZE-1:0] mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0]         mem_data_q, mem_data_d;
    logic                       mem_re_q, mem_re_d;
    logic                       mem_we_q, mem_we_d;
    logic [BLOCK_W-1:0]         rdata_q, rdata_d;
    logic [NUM_PORTS-1:0]       ack_q, ack_d;
    logic [NUM_PORTS-1:0]       rvalid_q, rvalid_d;

    logic                 grant_valid;
    logic [PTR_W-1:0]     grant_idx;
    logic [PTR_W:0]       scan_sum;
    logic [PTR_W-1:0]     scan_idx;

    // Round-robin search: first requesting port at or after the pointer, wrapping.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            scan_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_PORTS)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_PORTS);
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!grant_valid && in_req[scan_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    // State register with the transaction context it owns.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: grant in IDLE, count read latency in WAIT, advance pointer past the served port in RESP.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d = ISSUE;
                    sel_d   = grant_idx;
                    we_d    = in_we[grant_idx];
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(READ_LATENCY);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
                ptr_d   = (sel_q == PTR_W'(NUM_PORTS - 1)) ? '0 : sel_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output next values, decoded from the upcoming state so every output leaves a flop.
    always_comb begin
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        rdata_d    = rdata_q;
        mem_re_d   = 1'b0;
        mem_we_d   = 1'b0;
        ack_d      = '0;
        rvalid_d   = '0;
        if (state_q == IDLE && grant_valid) begin
            mem_addr_d = in_addr[grant_idx*LOG_MEMORY_SIZE +: LOG_MEMORY_SIZE];
            mem_data_d = in_wdata[grant_idx*BLOCK_W +: BLOCK_W];
            mem_we_d   = in_we[grant_idx];
            mem_re_d   = !in_we[grant_idx];
        end
        if (state_q == WAIT && cnt_q == CNT_W'(1)) begin
            rdata_d = in_mem_data;
        end
        if (state_d == RESP) begin
            ack_d[sel_q]    = 1'b1;
            rvalid_d[sel_q] = !we_q;
        end
    end

    // Output registers; reset clears them so an aborted transaction leaves no trace.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            rdata_q    <= '0;
            ack_q      <= '0;
            rvalid_q   <= '0;
        end else begin
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_re_q   <= mem_re_d;
            mem_we_q   <= mem_we_d;
            rdata_q    <= rdata_d;
            ack_q      <= ack_d;
            rvalid_q   <= rvalid_d;
        end
    end

    assign out_ack          = ack_q;
    assign out_rvalid       = rvalid_q;
    assign out_rdata        = rdata_q;
    assign out_mem_address  = mem_addr_q;
    assign out_mem_data     = mem_data_q;
    assign out_mem_read_en  = mem_re_q;
    assign out_mem_write_en = mem_we_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Directed bench for mem_port_responder: one instance with read latency 1,
// one with read latency 3, driven by the same requester stimulus.
module tb_mem_port_responder;

    logic         clk;
    logic         in_reset;
    logic [3:0]   in_req;
    logic [3:0]   in_we;
    logic [39:0]  in_addr;
    logic [383:0] in_wdata;
    logic [95:0]  in_mem_data;

    logic [3:0]   ack1, rvalid1, ack3, rvalid3;
    logic [95:0]  rdata1, mdata1, rdata3, mdata3;
    logic [9:0]   maddr1, maddr3;
    logic         ren1, wen1, ren3, wen3;

    int checks;
    int errors;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  we;
        int          port;
        logic [9:0]  addr;
        logic [95:0] wdata;
        logic [95:0] mdata;
        logic [3:0]  ack;
        logic [3:0]  rvalid;
        logic        wen;
        logic        ren;
        logic [9:0]  maddr;
        logic [95:0] mwdata;
        logic [95:0] rdata;
    } vec_t;

    vec_t vecs[9];

    mem_port_responder #(.READ_LATENCY(1)) dut1 (
        .in_clk(clk), .in_reset(in_reset), .in_req(in_req), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata), .out_ack(ack1), .out_rvalid(rvalid1),
        .out_rdata(rdata1), .out_mem_address(maddr1), .out_mem_data(mdata1),
        .out_mem_read_en(ren1), .out_mem_write_en(wen1), .in_mem_data(in_mem_data)
    );

    mem_port_responder #(.READ_LATENCY(3)) dut3 (
        .in_clk(clk), .in_reset(in_reset), .in_req(in_req), .in_we(in_we),
        .in_addr(in_addr), .in_wdata(in_wdata), .out_ack(ack3), .out_rvalid(rvalid3),
        .out_rdata(rdata3), .out_mem_address(maddr3), .out_mem_data(mdata3),
        .out_mem_read_en(ren3), .out_mem_write_en(wen3), .in_mem_data(in_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every port gets a distinct default address (100+p) and write block (0xF00+p).
    task automatic setBackground();
        for (int p = 0; p < 4; p++) begin
            in_addr[p*10 +: 10]   = 10'(100 + p);
            in_wdata[p*96 +: 96]  = 96'h0F00 + 96'(p);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        setBackground();
        in_req = v.req;
        in_we  = v.we;
        in_addr[v.port*10 +: 10]  = v.addr;
        in_wdata[v.port*96 +: 96] = v.wdata;
        in_mem_data = v.mdata;
    endtask

    task automatic doReset();
        in_reset    = 1'b1;
        in_req      = '0;
        in_we       = '0;
        in_mem_data = '0;
        setBackground();
        @(posedge clk); #1;
        in_reset = 1'b0;
    endtask

    // Holds requests until each port's ack, drops each port the cycle after its ack,
    // and checks grant order, ack cycle, rvalid and ack one-hotness; cycle 0 is the first request cycle.
    task automatic serveSequence(input logic [3:0] reqs, input logic [3:0] wes, input logic [7:0] order,
                                 input int n, input int first, input int gap, input bit slow);
        logic [3:0] pending;
        logic [3:0] a;
        logic [3:0] rv;
        logic [3:0] exp_mask;
        int served;
        pending = reqs;
        in_we   = wes;
        served  = 0;
        for (int cyc = 0; cyc < 60 && served < n; cyc++) begin
            in_req = pending;
            a  = slow ? ack3 : ack1;
            rv = slow ? rvalid3 : rvalid1;
            checkOutput("ack_onehot", 96'($countones(a) <= 1), 96'd1);
            if (a != 4'b0) begin
                exp_mask = 4'b0001 << order[served*2 +: 2];
                checkOutput("ack_port", 96'(a), 96'(exp_mask));
                checkOutput("ack_cycle", 96'(cyc), 96'(first + served*gap));
                checkOutput("rvalid", 96'(rv), 96'((wes & exp_mask) != 4'b0 ? 4'b0 : exp_mask));
                pending = pending & ~a;
                served++;
            end
            @(posedge clk); #1;
        end
        checkOutput("served_count", 96'(served), 96'(n));
        in_req = '0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] exp_ack;
        checks = 0;
        errors = 0;
        in_reset = 1'b0;
        in_req = '0;
        in_we = '0;
        in_mem_data = '0;
        setBackground();

        // Write by port 2 (addr 5, data A), then read by port 1 (addr 7) returning 0x1234.
        vecs[0] = '{4'b0100, 4'b0100, 2, 10'd5, 96'hA,  96'h0,    4'b0000, 4'b0000, 1'b0, 1'b0, 10'd0, 96'h0,  96'h0};
        vecs[1] = '{4'b0100, 4'b0100, 2, 10'd5, 96'hA,  96'h0,    4'b0000, 4'b0000, 1'b1, 1'b0, 10'd5, 96'hA,  96'h0};
        vecs[2] = '{4'b0100, 4'b0100, 2, 10'd5, 96'hA,  96'h0,    4'b0100, 4'b0000, 1'b0, 1'b0, 10'd5, 96'hA,  96'h0};
        vecs[3] = '{4'b0000, 4'b0000, 2, 10'd5, 96'hA,  96'h0,    4'b0000, 4'b0000, 1'b0, 1'b0, 10'd5, 96'hA,  96'h0};
        vecs[4] = '{4'b0010, 4'b0000, 1, 10'd7, 96'h77, 96'h0,    4'b0000, 4'b0000, 1'b0, 1'b0, 10'd5, 96'hA,  96'h0};
        vecs[5] = '{4'b0010, 4'b0000, 1, 10'd7, 96'h77, 96'h0,    4'b0000, 4'b0000, 1'b0, 1'b1, 10'd7, 96'h77, 96'h0};
        vecs[6] = '{4'b0010, 4'b0000, 1, 10'd7, 96'h77, 96'h1234, 4'b0000, 4'b0000, 1'b0, 1'b0, 10'd7, 96'h77, 96'h0};
        vecs[7] = '{4'b0010, 4'b0000, 1, 10'd7, 96'h77, 96'h0,    4'b0010, 4'b0010, 1'b0, 1'b0, 10'd7, 96'h77, 96'h1234};
        vecs[8] = '{4'b0000, 4'b0000, 1, 10'd7, 96'h77, 96'h0,    4'b0000, 4'b0000, 1'b0, 1'b0, 10'd7, 96'h77, 96'h1234};

        doReset();
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d_ack", i),    96'(ack1),    96'(vecs[i].ack));
            checkOutput($sformatf("v%0d_rvalid", i), 96'(rvalid1), 96'(vecs[i].rvalid));
            checkOutput($sformatf("v%0d_wen", i),    96'(wen1),    96'(vecs[i].wen));
            checkOutput($sformatf("v%0d_ren", i),    96'(ren1),    96'(vecs[i].ren));
            checkOutput($sformatf("v%0d_maddr", i),  96'(maddr1),  96'(vecs[i].maddr));
            checkOutput($sformatf("v%0d_mwdata", i), mdata1,       vecs[i].mwdata);
            checkOutput($sformatf("v%0d_rdata", i),  rdata1,       vecs[i].rdata);
            @(posedge clk); #1;
        end

        // All four ports read at once from reset: grants 0,1,2,3, acks 4 cycles apart.
        doReset();
        serveSequence(4'b1111, 4'b0000, 8'b11_10_01_00, 4, 3, 4, 1'b0);

        // Pointer has wrapped to 0: ports 0 and 3 write together, port 0 wins first.
        serveSequence(4'b1001, 4'b1001, 8'b0000_11_00, 2, 2, 3, 1'b0);

        // Reset in the WAIT cycle of a port 0 read aborts it and clears every output.
        doReset();
        in_req = 4'b0001;
        in_we  = 4'b0000;
        @(posedge clk); #1;
        checkOutput("abort_ren_issue", 96'(ren1), 96'd1);
        checkOutput("abort_maddr_issue", 96'(maddr1), 96'd100);
        @(posedge clk); #1;
        in_mem_data = 96'hDEAD;
        in_reset = 1'b1;
        @(posedge clk); #1;
        in_reset = 1'b0;
        in_req = '0;
        in_mem_data = '0;
        checkOutput("abort_ack", 96'(ack1), 96'd0);
        checkOutput("abort_rvalid", 96'(rvalid1), 96'd0);
        checkOutput("abort_rdata", rdata1, 96'd0);
        checkOutput("abort_maddr", 96'(maddr1), 96'd0);
        checkOutput("abort_mwdata", mdata1, 96'd0);
        checkOutput("abort_ren", 96'(ren1), 96'd0);
        serveSequence(4'b0110, 4'b0110, 8'b0000_10_01, 2, 2, 3, 1'b0);

        // Latency-3 read by port 0 with a port 2 write arriving mid-read; the write waits.
        doReset();
        in_we = 4'b0100;
        for (int cyc = 0; cyc < 10; cyc++) begin
            in_req = ((cyc <= 5) ? 4'b0001 : 4'b0000) | ((cyc >= 2 && cyc <= 8) ? 4'b0100 : 4'b0000);
            in_mem_data = (cyc == 4) ? 96'hBEEF : 96'h0;
            #1;
            exp_ack = (cyc == 5) ? 4'b0001 : ((cyc == 8) ? 4'b0100 : 4'b0000);
            checkOutput($sformatf("l3_c%0d_ack", cyc),    96'(ack3),    96'(exp_ack));
            checkOutput($sformatf("l3_c%0d_rvalid", cyc), 96'(rvalid3), 96'((cyc == 5) ? 4'b0001 : 4'b0000));
            checkOutput($sformatf("l3_c%0d_ren", cyc),    96'(ren3),    96'(cyc == 1));
            checkOutput($sformatf("l3_c%0d_wen", cyc),    96'(wen3),    96'(cyc == 7));
            checkOutput($sformatf("l3_c%0d_rdata", cyc),  rdata3,       (cyc >= 5) ? 96'hBEEF : 96'h0);
            if (cyc == 1 || cyc == 7) begin
                checkOutput($sformatf("l3_c%0d_maddr", cyc), 96'(maddr3), (cyc == 1) ? 96'd100 : 96'd102);
            end
            @(posedge clk); #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
